// File: rtl/sram_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter_if
// Purpose  : Requester-side handshake and SRAM-side bus for sram_port_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface sram_port_arbiter_if #(
    parameter int AW = 14
) ();
    logic          REQ0;
    logic          REQ1;
    logic          WE0;
    logic          WE1;
    logic [AW-1:0] ADDR0;
    logic [AW-1:0] ADDR1;
    logic [1:0]    SIZE0;
    logic [1:0]    SIZE1;
    logic [31:0]   WDATA0;
    logic [31:0]   WDATA1;
    logic          GNT0;
    logic          GNT1;
    logic          RVALID0;
    logic          RVALID1;
    logic [31:0]   RDATA0;
    logic [31:0]   RDATA1;
    logic          CSN;
    logic [AW-3:0] SADDR;
    logic          SWE;
    logic [3:0]    BE;
    logic [31:0]   DI;
    logic [31:0]   DO;

    modport slave (
        input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, SIZE0, SIZE1, WDATA0, WDATA1, DO,
        output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, CSN, SADDR, SWE, BE, DI
    );

    modport master (
        output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, SIZE0, SIZE1, WDATA0, WDATA1, DO,
        input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, CSN, SADDR, SWE, BE, DI
    );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Two-requester arbiter onto one single-cycle 32-bit SRAM port with
//            byte-lane mapping, read right-justify and optional sub-word RMW.
// Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int AW     = 14,
    parameter int RR_EN  = 1,
    parameter int RMW_EN = 1
) (
    input wire                 CLK,
    input wire                 RST,
    sram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RMW_RD  = 2'd2,
        ST_RMW_WR  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last;
    logic          r_id;
    logic [1:0]    r_lane;
    logic [1:0]    r_size;
    logic [31:0]   r_wdata;
    logic [AW-3:0] r_saddr;

    logic          w_any;
    logic          w_win;
    logic          w_we;
    logic          w_rmw;
    logic          w_grant;
    logic [AW-1:0] w_addr;
    logic [1:0]    w_size;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdata;

    function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'hF;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] f_lane_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'd0:    d = {4{wd[7:0]}};
            2'd1:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Misaligned accesses are aligned down to their natural boundary.
    function automatic logic [1:0] f_eff_lane(input logic [1:0] size, input logic [1:0] lane);
        logic [1:0] l;
        case (size)
            2'd0:    l = lane;
            2'd1:    l = {lane[1], 1'b0};
            default: l = 2'd0;
        endcase
        return l;
    endfunction

    function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [1:0] lane,
                                              input logic [1:0] size);
        logic [31:0] s;
        logic [31:0] r;
        s = d >> {lane, 3'b000};
        case (size)
            2'd0:    r = {24'd0, s[7:0]};
            2'd1:    r = {16'd0, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [3:0] be,
                                            input logic [31:0] nd);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? nd[8*i +: 8] : old[8*i +: 8];
        end
        return m;
    endfunction

    // On a tie, round-robin hands the port to whoever was not served last.
    assign w_any   = bus.REQ0 | bus.REQ1;
    assign w_win   = (bus.REQ0 && bus.REQ1) ? ((RR_EN != 0) ? ~r_last : 1'b0) : bus.REQ1;
    assign w_we    = w_win ? bus.WE1    : bus.WE0;
    assign w_addr  = w_win ? bus.ADDR1  : bus.ADDR0;
    assign w_size  = w_win ? bus.SIZE1  : bus.SIZE0;
    assign w_wdata = w_win ? bus.WDATA1 : bus.WDATA0;
    assign w_rmw   = (RMW_EN != 0) && !w_size[1];
    assign w_grant = (r_state == ST_IDLE) && w_any && !RST;
    assign w_rdata = f_extract(bus.DO, r_lane, r_size);

    always_comb begin
        w_state_nxt = r_state;
        bus.GNT0    = 1'b0;
        bus.GNT1    = 1'b0;
        bus.RVALID0 = 1'b0;
        bus.RVALID1 = 1'b0;
        bus.RDATA0  = 32'd0;
        bus.RDATA1  = 32'd0;
        bus.CSN     = 1'b1;
        bus.SWE     = 1'b0;
        bus.BE      = 4'd0;
        bus.SADDR   = '0;
        bus.DI      = 32'd0;
        if (!RST) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        bus.GNT0  = ~w_win;
                        bus.GNT1  = w_win;
                        bus.CSN   = 1'b0;
                        bus.SADDR = w_addr[AW-1:2];
                        if (!w_we) begin
                            bus.BE      = 4'hF;
                            w_state_nxt = ST_RD_WAIT;
                        end else if (w_rmw) begin
                            bus.BE      = 4'hF;
                            w_state_nxt = ST_RMW_RD;
                        end else begin
                            bus.SWE = 1'b1;
                            bus.BE  = f_be(w_size, w_addr[1:0]);
                            bus.DI  = f_lane_data(w_size, w_wdata);
                        end
                    end
                end
                ST_RD_WAIT: begin
                    bus.RVALID0 = ~r_id;
                    bus.RVALID1 = r_id;
                    bus.RDATA0  = r_id ? 32'd0 : w_rdata;
                    bus.RDATA1  = r_id ? w_rdata : 32'd0;
                    w_state_nxt = ST_IDLE;
                end
                // DO is the word read in the grant cycle; write it back fully.
                ST_RMW_RD: begin
                    bus.CSN     = 1'b0;
                    bus.SWE     = 1'b1;
                    bus.BE      = 4'hF;
                    bus.SADDR   = r_saddr;
                    bus.DI      = f_merge(bus.DO, f_be(r_size, r_lane),
                                          f_lane_data(r_size, r_wdata));
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_lane  <= 2'd0;
            r_size  <= 2'd0;
            r_wdata <= 32'd0;
            r_saddr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last  <= w_win;
                r_id    <= w_win;
                r_lane  <= f_eff_lane(w_size, w_addr[1:0]);
                r_size  <= w_size;
                r_wdata <= w_wdata;
                r_saddr <= w_addr[AW-1:2];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Three arbiter configurations (RR+RMW, fixed+RMW, RR+no-RMW) each
//            on its own SRAM model, checked against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        r_req   [3][2];
    logic        r_we    [3][2];
    logic [13:0] r_addr  [3][2];
    logic [1:0]  r_size  [3][2];
    logic [31:0] r_wdata [3][2];

    logic        w_gnt    [3][2];
    logic        w_rvalid [3][2];
    logic [31:0] w_rdata  [3][2];
    logic        w_csn    [3];
    logic        w_swe    [3];
    logic [3:0]  w_be     [3];
    logic [11:0] w_saddr  [3];
    logic [31:0] w_di     [3];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_port_arbiter_if #(.AW(14)) bus ();
        logic [31:0] mem [4096];
        logic [31:0] do_q;

        assign bus.REQ0   = r_req[g][0];
        assign bus.REQ1   = r_req[g][1];
        assign bus.WE0    = r_we[g][0];
        assign bus.WE1    = r_we[g][1];
        assign bus.ADDR0  = r_addr[g][0];
        assign bus.ADDR1  = r_addr[g][1];
        assign bus.SIZE0  = r_size[g][0];
        assign bus.SIZE1  = r_size[g][1];
        assign bus.WDATA0 = r_wdata[g][0];
        assign bus.WDATA1 = r_wdata[g][1];
        assign bus.DO     = do_q;

        assign w_gnt[g][0]    = bus.GNT0;
        assign w_gnt[g][1]    = bus.GNT1;
        assign w_rvalid[g][0] = bus.RVALID0;
        assign w_rvalid[g][1] = bus.RVALID1;
        assign w_rdata[g][0]  = bus.RDATA0;
        assign w_rdata[g][1]  = bus.RDATA1;
        assign w_csn[g]       = bus.CSN;
        assign w_swe[g]       = bus.SWE;
        assign w_be[g]        = bus.BE;
        assign w_saddr[g]     = bus.SADDR;
        assign w_di[g]        = bus.DI;

        sram_port_arbiter #(
            .AW    (14),
            .RR_EN ((g == 1) ? 0 : 1),
            .RMW_EN((g == 2) ? 0 : 1)
        ) u_dut (
            .CLK(clk),
            .RST(rst),
            .bus(bus)
        );

        // SRAM: command latched mid-cycle, applied on the rising edge.
        initial begin
            logic        s_csn;
            logic        s_swe;
            logic [3:0]  s_be;
            logic [11:0] s_sa;
            logic [31:0] s_di;
            for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
            do_q = 32'd0;
            forever begin
                @(negedge clk);
                s_csn = bus.CSN; s_swe = bus.SWE; s_be = bus.BE; s_sa = bus.SADDR; s_di = bus.DI;
                @(posedge clk);
                if (!s_csn) begin
                    if (s_swe) begin
                        for (int b = 0; b < 4; b++)
                            if (s_be[b]) mem[s_sa][8*b +: 8] = s_di[8*b +: 8];
                    end else begin
                        do_q <= mem[s_sa];
                    end
                end
            end
        end
    end

    task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got 0x%08h expected 0x%08h", k, name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [31:0] ref_mem [3][4096];
    int          m_busy [3];   // 0 none, 1 read data due, 2 RMW write due
    int          m_id   [3];
    int          m_off  [3];
    int          m_n    [3];
    int          m_sa   [3];
    int          m_last [3];
    logic [31:0] m_wd   [3];

    function automatic bit f_rr(input int k);  return k != 1; endfunction
    function automatic bit f_rmw(input int k); return k != 2; endfunction

    task automatic model_step(input int k);
        int          p, n, off, sa;
        logic [31:0] word, e_rd0, e_rd1, e_di, wd;
        logic        e_g0, e_g1, e_v0, e_v1, e_csn, e_swe;
        logic [3:0]  e_be;
        bit          chk_cmd, chk_di, idle_all;
        e_g0 = 0; e_g1 = 0; e_v0 = 0; e_v1 = 0; e_rd0 = 0; e_rd1 = 0;
        e_csn = 1; e_swe = 0; e_be = 0; e_di = 0; sa = 0;
        chk_cmd = 0; chk_di = 0; idle_all = 0;
        if (rst) begin
            idle_all = 1; m_busy[k] = 0; m_last[k] = 1;
        end else if (m_busy[k] == 1) begin
            word = ref_mem[k][m_sa[k]] >> (8 * m_off[k]);
            if (m_n[k] < 4) word = word & ((32'd1 << (8 * m_n[k])) - 32'd1);
            if (m_id[k] == 0) begin e_v0 = 1; e_rd0 = word; end
            else begin e_v1 = 1; e_rd1 = word; end
            m_busy[k] = 0;
        end else if (m_busy[k] == 2) begin
            word = ref_mem[k][m_sa[k]];
            for (int i = 0; i < m_n[k]; i++) word[8*(m_off[k]+i) +: 8] = m_wd[k][8*i +: 8];
            ref_mem[k][m_sa[k]] = word;
            e_csn = 0; e_swe = 1; e_be = 4'hF; sa = m_sa[k]; e_di = word;
            chk_cmd = 1; chk_di = 1; m_busy[k] = 0;
        end else if (!r_req[k][0] && !r_req[k][1]) begin
            idle_all = 1;
        end else begin
            if (r_req[k][0] && r_req[k][1]) p = f_rr(k) ? 1 - m_last[k] : 0;
            else p = r_req[k][1] ? 1 : 0;
            m_last[k] = p;
            e_g0 = (p == 0); e_g1 = (p == 1);
            n   = (r_size[k][p] == 0) ? 1 : (r_size[k][p] == 1) ? 2 : 4;
            off = (r_addr[k][p] % 4) - ((r_addr[k][p] % 4) % n);
            sa  = r_addr[k][p] / 4;
            wd  = r_wdata[k][p];
            e_csn = 0; chk_cmd = 1;
            m_id[k] = p; m_off[k] = off; m_n[k] = n; m_sa[k] = sa; m_wd[k] = wd;
            if (!r_we[k][p]) begin
                e_be = 4'hF; m_busy[k] = 1;
            end else if (f_rmw(k) && n < 4) begin
                e_be = 4'hF; m_busy[k] = 2;
            end else begin
                e_swe = 1; chk_di = 1;
                e_be  = 4'(((1 << n) - 1) << off);
                for (int i = 0; i < 4; i++) e_di[8*i +: 8] = wd[8*(i % n) +: 8];
                for (int i = 0; i < n; i++) ref_mem[k][sa][8*(off+i) +: 8] = wd[8*i +: 8];
            end
        end
        chk(k, "gnt0", w_gnt[k][0], e_g0);
        chk(k, "gnt1", w_gnt[k][1], e_g1);
        chk(k, "rvalid0", w_rvalid[k][0], e_v0);
        chk(k, "rvalid1", w_rvalid[k][1], e_v1);
        chk(k, "rdata0", w_rdata[k][0], e_rd0);
        chk(k, "rdata1", w_rdata[k][1], e_rd1);
        chk(k, "csn", w_csn[k], e_csn);
        if (chk_cmd || idle_all) begin
            chk(k, "swe", w_swe[k], e_swe);
            chk(k, "be", w_be[k], e_be);
            chk(k, "saddr", w_saddr[k], sa);
        end
        if (chk_di || idle_all) chk(k, "di", w_di[k], e_di);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_last[k] = 1;
            for (int a = 0; a < 4096; a++) ref_mem[k][a] = 32'd0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    // ---------------- directed stimulus ----------------
    logic        c_csn, c_swe, n_csn, n_swe, n_rv;
    logic [3:0]  c_be, n_be;
    logic [11:0] c_sa;
    logic [31:0] c_di, n_di, n_rd;

    // One request; captures the grant-cycle command and the following cycle.
    task automatic xfer(input int k, input int p, input logic w, input logic [13:0] a,
                        input logic [1:0] s, input logic [31:0] d, input bit rst_after);
        bit got;
        @(posedge clk); #1;
        r_we[k][p] = w; r_addr[k][p] = a; r_size[k][p] = s; r_wdata[k][p] = d; r_req[k][p] = 1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (w_gnt[k][p]) got = 1;
        end
        if (!got) chk(k, "grant_timeout", 0, 1);
        c_csn = w_csn[k]; c_swe = w_swe[k]; c_be = w_be[k]; c_sa = w_saddr[k]; c_di = w_di[k];
        @(posedge clk); #1;
        r_req[k][p] = 0;
        if (rst_after) rst = 1;
        @(negedge clk);
        n_csn = w_csn[k]; n_swe = w_swe[k]; n_be = w_be[k]; n_di = w_di[k];
        n_rv = w_rvalid[k][p]; n_rd = w_rdata[k][p];
    endtask

    task automatic contend(input int k, input logic [3:0] exp_seq);
        int seq [4];
        int tg  [4];
        int cnt;
        for (int i = 0; i < 4; i++) begin seq[i] = -1; tg[i] = 0; end
        @(posedge clk); #1;
        r_we[k][0] = 0; r_addr[k][0] = 14'h010; r_size[k][0] = 2;
        r_we[k][1] = 0; r_addr[k][1] = 14'h012; r_size[k][1] = 1;
        r_req[k][0] = 1; r_req[k][1] = 1;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 4; c++) begin
            @(negedge clk);
            if (w_gnt[k][0] || w_gnt[k][1]) begin
                seq[cnt] = w_gnt[k][1] ? 1 : 0; tg[cnt] = c; cnt++;
            end
        end
        @(posedge clk); #1;
        r_req[k][0] = 0; r_req[k][1] = 0;
        chk(k, "contend_count", cnt, 4);
        for (int i = 0; i < 4; i++) chk(k, "contend_winner", seq[i], exp_seq[i]);
        if (cnt == 4)
            for (int i = 0; i < 3; i++) chk(k, "contend_spacing", tg[i+1] - tg[i], 2);
    endtask

    initial begin
        int t0, t1;
        bit g0, g1;
        rst = 1;
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < 2; p++) begin
                r_req[k][p] = 0; r_we[k][p] = 0; r_addr[k][p] = 0;
                r_size[k][p] = 0; r_wdata[k][p] = 0;
            end
        r_addr[0][0] = 14'h010; r_size[0][0] = 2; r_req[0][0] = 1;

        // Reset with a pending request, then the first IDLE cycle grants it.
        repeat (2) begin
            @(negedge clk);
            chk(0, "rst_csn", w_csn[0], 1);
            chk(0, "rst_gnt0", w_gnt[0][0], 0);
            chk(0, "rst_rvalid0", w_rvalid[0][0], 0);
        end
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk(0, "first_gnt0", w_gnt[0][0], 1);
        @(posedge clk); #1; r_req[0][0] = 0;
        @(negedge clk);
        chk(0, "first_rvalid0", w_rvalid[0][0], 1);

        // Word write, read-back, byte RMW, halfword read.
        xfer(0, 0, 1, 14'h010, 2, 32'hDEADBEEF, 0);
        chk(0, "ww_saddr", c_sa, 4);
        chk(0, "ww_be", c_be, 4'hF);
        chk(0, "ww_swe", c_swe, 1);
        chk(0, "ww_single_cycle", n_csn, 1);
        xfer(0, 0, 0, 14'h010, 2, 0, 0);
        chk(0, "wr_rvalid", n_rv, 1);
        chk(0, "wr_rdata", n_rd, 32'hDEADBEEF);
        xfer(0, 1, 1, 14'h013, 0, 32'h5A, 0);
        chk(0, "rmw_first_is_read", c_swe, 0);
        chk(0, "rmw_swe", n_swe, 1);
        chk(0, "rmw_be", n_be, 4'hF);
        chk(0, "rmw_di", n_di, 32'h5AADBEEF);
        xfer(0, 1, 0, 14'h012, 1, 0, 0);
        chk(0, "half_rdata", n_rd, 32'h00005AAD);

        // Tie behaviour straight after reset.
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        contend(0, 4'b1010);
        contend(1, 4'b0000);

        // Back-to-back word writes from both sides.
        @(posedge clk); #1;
        r_we[0][0] = 1; r_addr[0][0] = 14'h080; r_size[0][0] = 2; r_wdata[0][0] = 32'hA5A50001;
        r_we[0][1] = 1; r_addr[0][1] = 14'h084; r_size[0][1] = 2; r_wdata[0][1] = 32'h5A5A0002;
        r_req[0][0] = 1; r_req[0][1] = 1;
        t0 = -1; t1 = -1;
        for (int c = 0; c < 10 && (r_req[0][0] || r_req[0][1]); c++) begin
            @(negedge clk);
            g0 = w_gnt[0][0]; g1 = w_gnt[0][1];
            if (g0) t0 = c;
            if (g1) t1 = c;
            @(posedge clk); #1;
            if (g0) r_req[0][0] = 0;
            if (g1) r_req[0][1] = 0;
        end
        r_req[0][0] = 0; r_req[0][1] = 0;
        chk(0, "b2b_both", (t0 >= 0 && t1 >= 0), 1);
        chk(0, "b2b_gap", (t0 > t1) ? t0 - t1 : t1 - t0, 1);
        xfer(0, 0, 0, 14'h084, 2, 0, 0);
        chk(0, "b2b_rdata", n_rd, 32'h5A5A0002);

        // Reset lands in the RMW write cycle: the write must vanish.
        xfer(0, 0, 1, 14'h020, 2, 32'h11223344, 0);
        xfer(0, 0, 1, 14'h021, 0, 32'hAA, 1);
        chk(0, "rstrmw_first_is_read", c_swe, 0);
        chk(0, "rstrmw_no_write", n_csn, 1);
        @(posedge clk); #1; rst = 0;
        xfer(0, 0, 0, 14'h020, 2, 0, 0);
        chk(0, "rstrmw_rdata", n_rd, 32'h11223344);

        // Partial-BE write path.
        xfer(2, 0, 1, 14'h001, 0, 32'h77, 0);
        chk(2, "pbe_be", c_be, 4'b0010);
        chk(2, "pbe_di", c_di, 32'h77777777);
        chk(2, "pbe_swe", c_swe, 1);
        chk(2, "pbe_single_cycle", n_csn, 1);
        xfer(2, 0, 0, 14'h000, 2, 0, 0);
        chk(2, "pbe_rdata", n_rd, 32'h00007700);

        // Lane/alignment table on every configuration.
        for (int k = 0; k < 3; k++) begin
            xfer(k, 1, 1, 14'h043, 1, 32'hBEEF, 0);
            xfer(k, 1, 1, 14'h040, 0, 32'h12, 0);
            xfer(k, 1, 0, 14'h040, 2, 0, 0);
            chk(k, "tbl_word", n_rd, 32'hBEEF0012);
            xfer(k, 1, 0, 14'h042, 0, 0, 0);
            chk(k, "tbl_byte", n_rd, 32'h000000EF);
            xfer(k, 1, 0, 14'h041, 1, 0, 0);
            chk(k, "tbl_half", n_rd, 32'h00000012);
            xfer(k, 1, 0, 14'h043, 2, 0, 0);
            chk(k, "tbl_misaligned_word", n_rd, 32'hBEEF0012);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares one port of the 4096x32 single-cycle SRAM between two requesters. M0 is the CPU data side and has priority. M1 is the loader/debug side. The block arbitrates requests, converts byte addresses and sizes into word address, byte enables and lane-replicated write data, and right-justifies read data. Sub-word writes are optionally done as read-modify-write, so the memory port never sees a partial-BE write.

Parameters:
AW, 14, requester byte-address width; SRAM word address = ADDR[AW-1:2] (12 bits)
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, M0 wins
RMW_EN, 1, 1 = sub-word writes done as read then full-word write; 0 = single partial-BE write

Ports:
CLK  in  1  clock, all state on posedge
RST  in  1  synchronous active-high reset
REQ0/REQ1  in  1  access request; held with fields stable until GNTx
WE0/WE1  in  1  1 = write, 0 = read
ADDR0/ADDR1  in  AW  byte address
SIZE0/SIZE1  in  2  0 = byte, 1 = halfword, 2 or 3 = word
WDATA0/WDATA1  in  32  write data, right-justified
GNT0/GNT1  out  1  combinational one-cycle accept pulse
RVALID0/RVALID1  out  1  read data valid, one cycle
RDATA0/RDATA1  out  32  read data, right-justified, zero-extended; 0 when RVALID low
CSN  out  1  SRAM chip select, active low
SADDR  out  12  SRAM word address
SWE  out  1  SRAM write enable
BE  out  4  SRAM byte enables
DI  out  32  SRAM write data
DO  in  32  SRAM read data, valid the cycle after a read command

Behaviour:
- Reset and idle values:
  - RST (synchronous) forces state IDLE and round-robin pointer to "last = M1", so M0 wins the first tie.
  - While RST is high, or in IDLE with no request: CSN=1, SWE=0, BE=0, SADDR=0, DI=0.
  - Outputs are also 0 in that case: GNTx=0, RVALIDx=0, RDATAx=0.
- Reset mid-operation: any pending RMW write is dropped and any pending RVALID is suppressed.
- States: IDLE, RD_WAIT, RMW_RD, RMW_WR.
- Arbitration (IDLE only, combinational from REQx):
  - Only one REQ high: that requester wins.
  - Both high, RR_EN=1: the requester not granted last time wins.
  - Both high, RR_EN=0: M0 wins.
  - The pointer updates on every grant.
- Grant cycle t (IDLE, winner w):
  - GNTw=1; the SRAM command is driven combinationally in cycle t.
  - Captured into registers: id, lane ADDR[1:0], size, WDATA, SADDR.
- Lane mapping:
  - Byte: BE = 1<<ADDR[1:0]; DI = {4{WDATA[7:0]}}.
  - Halfword: BE = ADDR[1] ? 4'b1100 : 4'b0011; DI = {2{WDATA[15:0]}}.
  - Word: BE = 4'hF; DI = WDATA.
  - Misaligned addresses are aligned down; offending low bits are ignored, no error.
- Read in cycle t:
  - Command: CSN=0, SWE=0, BE=4'hF; go to RD_WAIT.
  - Cycle t+1: RVALIDw=1; RDATAw = DO >> (8*lane) masked to size; return to IDLE.
  - No new grant in RD_WAIT, so reads take 2 cycles per access.
- Word write, or any write with RMW_EN=0:
  - Cycle t: CSN=0, SWE=1, BE per mapping; stay in IDLE.
  - A new grant is possible in t+1 (back-to-back writes at 1 per cycle).
- Sub-word write with RMW_EN=1:
  - Cycle t: read command with BE=F; go to RMW_RD.
  - Cycle t+1: CSN=0, SWE=1, BE=4'hF; DI = DO with the enabled lanes replaced by the lane data; then IDLE.
  - RMW_WR is reserved for a registered-DO variant and is unused at default; the implementation may fold it into RMW_RD.
- No grants are issued outside IDLE; the requester keeps REQ high and waits.
- Requests arriving while busy are granted in the first IDLE cycle.
- Writes have no response beyond GNT.

Test Plan:
- Reset: RST=1 for 2 cycles with REQ0=1 -> CSN=1, GNT0=0, RVALID0=0; first IDLE cycle after RST falls -> GNT0=1.
- Word write then read: M0 word write 0xDEADBEEF @0x010 (SADDR=4, BE=F, 1 cycle); then read @0x010 -> RVALID0 one cycle after GNT0, RDATA0=0xDEADBEEF.
- Byte RMW: M1 byte write 0x5A @0x013 after the above -> SRAM read then write DI=0x5AADBEEF, BE=F; halfword read @0x012 -> RDATA1=0x00005AAD.
- Contention, RR_EN=1: REQ0=REQ1=1 held for 4 reads -> grants M0, M1, M0, M1, one every 2 cycles; RVALID follows the correct id. With RR_EN=0 -> M0 wins every tie.
- RMW_EN=0: byte write 0x77 @0x001 -> single cycle, BE=4'b0010, DI=0x77777777.
- Reset during RMW_RD: assert RST in cycle t+1 -> no write (CSN=1); later word read of that address returns the prior contents unchanged.
